instr_byte_loader: RTL and testbench

Upstream stage of the single-cycle MIPS control path on the TinyTapeout tile. It assembles 32-bit instructions from a byte-serial input stream using a valid/ready handshake. It holds each completed instruction and presents decoded fields (opcode, funct, rs/rt/rd, shamt, imm) to the main and ALU control units. It also maintains the program counter, including branch redirection.

---
 rtl/instr_byte_loader_pkg.sv | 43 ++++
 rtl/instr_byte_loader_pc_next.sv | 25 ++
 rtl/instr_byte_loader.sv | 139 +++++++++++++
 tb/tb_instr_byte_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_byte_loader_pkg.sv
// Shared definitions for the instruction byte loader.
// Holds opcode constants, instruction field bit positions, the loader
// state encoding and a legality helper for the optional illegal-opcode
// detector (enabled by defining ILLEGAL_OP_DETECT_EN).
package instr_byte_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam int BYTES_PER_INSTR = 4;
  localparam int COUNT_W         = $clog2(BYTES_PER_INSTR);
  localparam logic [COUNT_W-1:0] LAST_BYTE_IDX = COUNT_W'(BYTES_PER_INSTR - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } loader_state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/instr_byte_loader_pc_next.sv
// pc_next_calc: combinational next-PC for the consume handshake.
// Ports:
//   pc           current program counter
//   imm          16-bit immediate of the held instruction
//   branch_taken select pc+4+(sext(imm)<<2) instead of pc+4
//   next_pc      result, wrapped modulo 2^PC_W
import instr_byte_loader_pkg::*;

module pc_next_calc #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             branch_taken,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] offset;

  // Sign-extend and scale to a word offset; bits above PC_W are dropped
  // because the sum wraps anyway.
  assign offset  = PC_W'({{PC_W{imm[IMM_W-1]}}, imm, 2'b00});
  assign next_pc = pc + PC_W'(4) + (branch_taken ? offset : '0);

endmodule

// File: rtl/instr_byte_loader.sv
// instr_byte_loader: assembles big-endian 32-bit instructions from a
// byte-serial valid/ready stream, holds each one for the control stage,
// exposes decoded MIPS fields and tracks the program counter.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   byte_in/byte_valid/byte_ready  byte stream input handshake
//   flush                      synchronous abort of partial/held instruction
//   instr_valid/instr_ready    held instruction handshake
//   branch_taken               branch select, sampled on consume
//   opcode..imm                field slices of the held instruction
//   pc                         address of the held/next instruction
//   instr_illegal              held opcode is unsupported (ILLEGAL_OP_DETECT_EN)
// Optional feature macro: ILLEGAL_OP_DETECT_EN (undefined -> instr_illegal=0).
//
// state   | meaning
// COLLECT | accepting bytes, count = bytes gathered so far
// HOLD    | full instruction presented, waiting for consume
import instr_byte_loader_pkg::*;

module instr_byte_loader #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  input  logic            flush,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            instr_illegal
);

  loader_state_e        state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      pc_q, pc_d, pc_consume;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next (
    .pc           (pc_q),
    .imm          (instr_q[IMM_MSB:IMM_LSB]),
    .branch_taken (branch_taken),
    .next_pc      (pc_consume)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      // Flush wins over both handshakes: a 4th byte is dropped and a
      // consume does not advance pc.
      state_d = COLLECT;
      count_d = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (byte_valid) begin
            instr_d = {instr_q[INSTR_W-9:0], byte_in};
            if (count_q == LAST_BYTE_IDX) begin
              state_d = HOLD;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = COLLECT;
            count_d = '0;
            pc_d    = pc_consume;
          end
        end
        default: begin
          state_d = COLLECT;
          count_d = '0;
        end
      endcase
    end
  end

  assign byte_ready  = (state_q == COLLECT);
  assign instr_valid = (state_q == HOLD);
  assign pc          = pc_q;

  assign opcode = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign rs     = instr_q[RS_MSB:RS_LSB];
  assign rt     = instr_q[RT_MSB:RT_LSB];
  assign rd     = instr_q[RD_MSB:RD_LSB];
  assign shamt  = instr_q[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign imm    = instr_q[IMM_MSB:IMM_LSB];

`ifdef ILLEGAL_OP_DETECT_EN
  logic illegal_q, illegal_d;

  // The flag tracks the next held instruction, so it rises with instr_valid
  // and falls on consume or flush.
  always_comb begin
    illegal_d = (state_d == HOLD) && !is_legal_op(instr_d[OPCODE_MSB:OPCODE_LSB]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign instr_illegal = illegal_q;
`else
  assign instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_byte_loader.sv
module tb_instr_byte_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        instr_illegal;

  int total = 0;
  int bad   = 0;

`ifdef ILLEGAL_OP_DETECT_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  instr_byte_loader #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .flush         (flush),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .funct         (funct),
    .imm           (imm),
    .pc            (pc),
    .instr_illegal (instr_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        br;
    logic [15:0] pc_before;
    logic [15:0] pc_after;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("valid_before_last_byte", {31'd0, instr_valid}, 32'd0);
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  initial begin
    vecs[0] = '{32'h8CA20008, 1'b0, 16'h0000, 16'h0004, 6'h23, 5'd5, 5'd2, 5'd0,  5'd0,  6'h08, 16'h0008, 1'b0};
    vecs[1] = '{32'h00430820, 1'b0, 16'h0004, 16'h0008, 6'h00, 5'd2, 5'd3, 5'd1,  5'd0,  6'h20, 16'h0820, 1'b0};
    vecs[2] = '{32'h1022FFFE, 1'b1, 16'h0008, 16'h0004, 6'h04, 5'd1, 5'd2, 5'h1F, 5'h1F, 6'h3E, 16'hFFFE, 1'b0};
    vecs[3] = '{32'hFC000000, 1'b1, 16'h0004, 16'h0008, 6'h3F, 5'd0, 5'd0, 5'd0,  5'd0,  6'h00, 16'h0000, 1'b1};
    vecs[4] = '{32'h1000FFFD, 1'b1, 16'h0008, 16'h0000, 6'h04, 5'd0, 5'd0, 5'h1F, 5'h1F, 6'h3D, 16'hFFFD, 1'b0};
    vecs[5] = '{32'h10008000, 1'b1, 16'h0000, 16'h0004, 6'h04, 5'd0, 5'd0, 5'h10, 5'd0,  6'h00, 16'h8000, 1'b0};
    vecs[6] = '{32'hACA20010, 1'b0, 16'h0004, 16'h0008, 6'h2B, 5'd5, 5'd2, 5'd0,  5'd0,  6'h10, 16'h0010, 1'b0};

    rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0;
    instr_ready = 1'b0; branch_taken = 1'b0;
    #12;
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_byte_ready",  {31'd0, byte_ready}, 32'd1);
    chk("rst_pc",          {16'd0, pc}, 32'd0);
    chk("rst_opcode",      {26'd0, opcode}, 32'd0);
    chk("rst_imm",         {16'd0, imm}, 32'd0);
    chk("rst_illegal",     {31'd0, instr_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      send_word(vecs[v].word);
      chk("hold_valid",   {31'd0, instr_valid}, 32'd1);
      chk("hold_ready",   {31'd0, byte_ready}, 32'd0);
      chk("hold_pc",      {16'd0, pc}, {16'd0, vecs[v].pc_before});
      chk("f_opcode",     {26'd0, opcode}, {26'd0, vecs[v].op});
      chk("f_rs",         {27'd0, rs}, {27'd0, vecs[v].rs});
      chk("f_rt",         {27'd0, rt}, {27'd0, vecs[v].rt});
      chk("f_rd",         {27'd0, rd}, {27'd0, vecs[v].rd});
      chk("f_shamt",      {27'd0, shamt}, {27'd0, vecs[v].sh});
      chk("f_funct",      {26'd0, funct}, {26'd0, vecs[v].fn});
      chk("f_imm",        {16'd0, imm}, {16'd0, vecs[v].imm});
      chk("f_illegal",    {31'd0, instr_illegal}, {31'd0, vecs[v].ill & ILL_EN});
      // stall with a stray byte offered; it must be ignored
      byte_in = 8'hEE; byte_valid = 1'b1;
      tick(); tick();
      byte_valid = 1'b0;
      chk("stall_valid",  {31'd0, instr_valid}, 32'd1);
      chk("stall_imm",    {16'd0, imm}, {16'd0, vecs[v].imm});
      chk("stall_pc",     {16'd0, pc}, {16'd0, vecs[v].pc_before});
      instr_ready = 1'b1; branch_taken = vecs[v].br;
      tick();
      instr_ready = 1'b0; branch_taken = 1'b0;
      chk("consume_valid", {31'd0, instr_valid}, 32'd0);
      chk("consume_ready", {31'd0, byte_ready}, 32'd1);
      chk("consume_pc",    {16'd0, pc}, {16'd0, vecs[v].pc_after});
      chk("consume_ill",   {31'd0, instr_illegal}, 32'd0);
    end

    // flush after 2 bytes, then a clean R-type (pc = 8 here)
    send_byte(8'hAA);
    send_byte(8'hBB);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_partial_valid", {31'd0, instr_valid}, 32'd0);
    chk("flush_partial_pc",    {16'd0, pc}, 32'h0008);
    send_word(32'h00430820);
    chk("after_flush_valid", {31'd0, instr_valid}, 32'd1);
    chk("after_flush_imm",   {16'd0, imm}, 32'h0820);
    chk("after_flush_funct", {26'd0, funct}, 32'h20);
    chk("after_flush_rd",    {27'd0, rd}, 32'd1);
    chk("after_flush_rs",    {27'd0, rs}, 32'd2);
    instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    chk("after_flush_pc", {16'd0, pc}, 32'h000C);

    // flush coinciding with the 4th byte
    send_byte(8'h8C); send_byte(8'hA2); send_byte(8'h00);
    flush = 1'b1; send_byte(8'h08); flush = 1'b0;
    chk("flush4_valid", {31'd0, instr_valid}, 32'd0);
    chk("flush4_ready", {31'd0, byte_ready}, 32'd1);
    chk("flush4_pc",    {16'd0, pc}, 32'h000C);
    send_word(32'h8CA20008);
    chk("flush4_next_valid", {31'd0, instr_valid}, 32'd1);
    chk("flush4_next_imm",   {16'd0, imm}, 32'h0008);
    chk("flush4_next_op",    {26'd0, opcode}, 32'h23);

    // flush coinciding with a consume
    flush = 1'b1; instr_ready = 1'b1; branch_taken = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    chk("flushc_valid", {31'd0, instr_valid}, 32'd0);
    chk("flushc_pc",    {16'd0, pc}, 32'h000C);
    tick();
    chk("flushc_pc_later", {16'd0, pc}, 32'h000C);

    // illegal opcode held, then flushed
    send_word(32'hFC000000);
    chk("ill_held",    {31'd0, instr_illegal}, {31'd0, ILL_EN});
    flush = 1'b1; tick(); flush = 1'b0;
    chk("ill_flushed", {31'd0, instr_illegal}, 32'd0);

    // async reset mid-assembly
    send_byte(8'h11); send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc",    {16'd0, pc}, 32'd0);
    chk("arst_ready", {31'd0, byte_ready}, 32'd1);
    chk("arst_imm",   {16'd0, imm}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_word(32'h00430820);
    chk("arst_next_imm", {16'd0, imm}, 32'h0820);
    chk("arst_next_pc",  {16'd0, pc}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
